// File: rtl/wb_pseudorandom_if.sv
// Wishbone slave bus bundle for the pseudorandom peripheral.
// Signal names are from the slave's point of view.
interface wb_pseudorandom_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_pseudorandom.sv
// Wishbone slave holding a 32-bit Galois LFSR that firmware can seed, step,
// read and count, with a step-burst engine and a burst-done interrupt.
module wb_pseudorandom #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468,
  parameter logic [31:0] POLY         = 32'h8020_0003
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_pseudorandom_if.slave     wbs,
  output logic [7:0]           rnd_o,
  output logic                 irq_o
);

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_SEED   = 6'h01;
  localparam logic [5:0] OFF_DATA   = 6'h02;
  localparam logic [5:0] OFF_COUNT  = 6'h03;
  localparam logic [5:0] OFF_STEP   = 6'h04;
  localparam logic [5:0] OFF_STATUS = 6'h05;

  logic [31:0] state_q, state_d;
  logic [31:0] seed_q, seed_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [15:0] burst_q, burst_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic        req, wr, rd;
  logic [5:0]  off;
  logic [31:0] seed_merged, seed_new, step_val, rd_mux;
  logic        seed_wr, read_step, do_step, busy;

  assign req  = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q &
                (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr   = req & wbs.wbs_we_i;
  assign rd   = req & ~wbs.wbs_we_i;
  assign off  = wbs.wbs_adr_i[7:2];
  assign busy = (burst_q != 16'd0);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_seed_bytes
      assign seed_merged[gi*8 +: 8] = wbs.wbs_sel_i[gi] ? wbs.wbs_dat_i[gi*8 +: 8]
                                                        : seed_q[gi*8 +: 8];
    end
  endgenerate

  // A zero seed would lock the LFSR, so it is replaced before it lands anywhere.
  assign seed_new  = (seed_merged == 32'd0) ? SEED_DEFAULT : seed_merged;
  assign seed_wr   = wr && (off == OFF_SEED);
  assign read_step = rd && (off == OFF_DATA) && ctrl_q[1];
  assign do_step   = ctrl_q[0] | busy | read_step;
  assign step_val  = state_q[0] ? ((state_q >> 1) ^ POLY) : (state_q >> 1);

  always_comb begin
    rd_mux = 32'd0;
    case (off)
      OFF_CTRL:   rd_mux = {29'd0, ctrl_q};
      OFF_SEED:   rd_mux = seed_q;
      OFF_DATA:   rd_mux = state_q;
      OFF_COUNT:  rd_mux = count_q;
      OFF_STEP:   rd_mux = {16'd0, burst_q};
      OFF_STATUS: rd_mux = {30'd0, done_q, busy};
      default:    rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    ctrl_d  = ctrl_q;
    count_d = count_q;
    burst_d = burst_q;
    done_d  = done_q;
    ack_d   = req;
    dat_d   = rd ? rd_mux : 32'd0;

    if (rd && (off == OFF_STATUS)) done_d = 1'b0;

    // Seed load beats stepping and cancels any burst in flight.
    if (seed_wr) begin
      state_d = seed_new;
      seed_d  = seed_new;
      burst_d = 16'd0;
    end else if (do_step) begin
      state_d = step_val;
      count_d = count_q + 32'd1;
      if (busy) begin
        burst_d = burst_q - 16'd1;
        if (burst_q == 16'd1) done_d = 1'b1;
      end
    end

    if (wr && (off == OFF_CTRL) && wbs.wbs_sel_i[0]) ctrl_d = wbs.wbs_dat_i[2:0];
    if (wr && (off == OFF_COUNT)) count_d = 32'd0;
    if (wr && (off == OFF_STEP) && (wbs.wbs_dat_i[15:0] != 16'd0))
      burst_d = wbs.wbs_dat_i[15:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= SEED_DEFAULT;
      seed_q  <= SEED_DEFAULT;
      ctrl_q  <= 3'b010;
      count_q <= 32'd0;
      burst_q <= 16'd0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      burst_q <= burst_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign rnd_o         = state_q[7:0];
  assign irq_o         = done_q & ctrl_q[2];

endmodule

// File: tb/tb_wb_pseudorandom.sv
// Directed bench for wb_pseudorandom: each task drives one scenario and
// checks hand-computed values inline.
module tb_wb_pseudorandom;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rnd;
  logic       irq;
  int         vectors = 0;
  int         miscompares = 0;

  wb_pseudorandom_if bus ();

  wb_pseudorandom dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus.slave),
    .rnd_o    (rnd),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] B = 32'h3000_0000;

  task automatic bus_idle();
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'd0;
    bus.wbs_dat_i = 32'd0;
  endtask

  // Called just after a rising edge; returns just after the ack edge.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata, output bit acked);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    acked = 1'b0;
    rdata = 32'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rdata = bus.wbs_dat_o;
        break;
      end
    end
    bus_idle();
  endtask

  task automatic wr_reg(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    bit a;
    wb_xfer(1'b1, adr, dat, sel, r, a);
    vectors++;
    if (!a) begin
      miscompares++;
      $display("FAIL wr_ack adr=%h: no ack, required ack", adr);
    end else
      $display("write adr=%h dat=%h sel=%b acked", adr, dat, sel);
  endtask

  task automatic rd_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    bit a;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, r, a);
    vectors++;
    if (!a || r !== exp) begin
      miscompares++;
      $display("FAIL %s adr=%h: got %h ack=%0d, required %h", name, adr, r, a, exp);
    end else
      $display("read  %s adr=%h dat=%h", name, adr, r);
  endtask

  task automatic test_reset();
    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'd0 || irq !== 1'b0 || rnd !== 8'h68) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b dat=%h irq=%b rnd=%h, required 0 0 0 68",
               bus.wbs_ack_o, bus.wbs_dat_o, irq, rnd);
    end else
      $display("reset outputs ok");
    rst = 1'b0;
    rd_check("count_at_reset", B + 32'h0C, 32'd0);
    rd_check("data_at_reset", B + 32'h08, 32'hACE1_2468);
    @(posedge clk);
    #1;
    vectors++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'd0) begin
      miscompares++;
      $display("FAIL ack_one_cycle: ack=%b dat=%h, required 0 00000000", bus.wbs_ack_o, bus.wbs_dat_o);
    end else
      $display("ack dropped after one cycle");
    rd_check("count_after_read_step", B + 32'h0C, 32'd1);
    rd_check("ctrl_at_reset", B + 32'h00, 32'h2);
  endtask

  task automatic test_step_on_read();
    wr_reg(B + 32'h0C, 32'hDEAD_BEEF, 4'hF);
    wr_reg(B + 32'h04, 32'h0000_0001, 4'hF);
    rd_check("data0", B + 32'h08, 32'h0000_0001);
    rd_check("data1", B + 32'h08, 32'h8020_0003);
    rd_check("data2", B + 32'h08, 32'hC030_0002);
    rd_check("count3", B + 32'h0C, 32'd3);
  endtask

  task automatic test_seed_zero();
    wr_reg(B + 32'h04, 32'h0000_0000, 4'hF);
    rd_check("zero_seed_subst", B + 32'h08, 32'hACE1_2468);
    rd_check("seed_reg_subst", B + 32'h04, 32'hACE1_2468);
    wr_reg(B + 32'h04, 32'h0000_0055, 4'b0001);
    rd_check("byte_seed", B + 32'h08, 32'hACE1_2455);
  endtask

  task automatic test_ctrl();
    wr_reg(B + 32'h00, 32'hFFFF_FFF8, 4'hF);
    rd_check("ctrl_upper_zero", B + 32'h00, 32'h0);
    wr_reg(B + 32'h00, 32'h0000_00FF, 4'b1110);
    rd_check("ctrl_sel0_gate", B + 32'h00, 32'h0);
    rd_check("other_offset", B + 32'h18, 32'h0);
  endtask

  task automatic test_burst();
    wr_reg(B + 32'h00, 32'h4, 4'hF);
    wr_reg(B + 32'h04, 32'h1, 4'hF);
    wr_reg(B + 32'h10, 32'h2, 4'hF);
    rd_check("status_busy", B + 32'h14, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_set: irq=%b, required 1", irq);
    end else
      $display("irq raised after burst");
    rd_check("burst_data", B + 32'h08, 32'hC030_0002);
    rd_check("status_done", B + 32'h14, 32'h2);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear: irq=%b, required 0", irq);
    end else
      $display("irq cleared by status read");
    rd_check("status_idle", B + 32'h14, 32'h0);
  endtask

  task automatic test_burst_cancel();
    wr_reg(B + 32'h00, 32'h0, 4'hF);
    wr_reg(B + 32'h0C, 32'h0, 4'hF);
    wr_reg(B + 32'h10, 32'd100, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    wr_reg(B + 32'h04, 32'h1234_5678, 4'hF);
    rd_check("cancel_status", B + 32'h14, 32'h0);
    rd_check("cancel_data", B + 32'h08, 32'h1234_5678);
    rd_check("cancel_count", B + 32'h0C, 32'd5);
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    bit prev = 1'b0;
    bit consec = 1'b0;
    bit bad_dat = 1'b0;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = B + 32'h1C;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        acks++;
        if (prev) consec = 1'b1;
        if (bus.wbs_dat_o !== 32'd0) bad_dat = 1'b1;
      end
      prev = bus.wbs_ack_o;
    end
    bus_idle();
    vectors++;
    if (acks != 4 || consec || bad_dat) begin
      miscompares++;
      $display("FAIL back_to_back: acks=%0d consecutive=%0d bad_dat=%0d, required 4 0 0", acks, consec, bad_dat);
    end else
      $display("back-to-back: 4 acks in 8 cycles, alternating");
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    bit a;
    wr_reg(B + 32'h00, 32'h1, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = B + 32'h08;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'd0 || irq !== 1'b0 || rnd !== 8'h68) begin
        miscompares++;
        $display("FAIL reset_abort: ack=%b dat=%h irq=%b rnd=%h, required 0 0 0 68",
                 bus.wbs_ack_o, bus.wbs_dat_o, irq, rnd);
      end else
        $display("reset during access: no ack, outputs at reset values");
    end
    bus_idle();
    rst = 1'b0;
    rd_check("count_after_abort", B + 32'h0C, 32'd0);
    rd_check("data_after_abort", B + 32'h08, 32'hACE1_2468);
    wb_xfer(1'b0, 32'h3000_1000, 32'd0, 4'hF, r, a);
    vectors++;
    if (a) begin
      miscompares++;
      $display("FAIL foreign_addr: ack=1, required no ack");
    end else
      $display("access to 30001000 not acked");
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_step_on_read();
    test_seed_zero();
    test_ctrl();
    test_burst();
    test_burst_cancel();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
